ssd_score_scanner: RTL and testbench

//  Parametrised score display driver for the board seven-segment display.

---
 rtl/ssd_score_scanner.sv | 196 +++++++++++++++++++
 tb/tb_ssd_score_scanner.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ssd_score_scanner.sv
// Binary score -> BCD (sequential double-dabble) -> time-multiplexed N-digit seven-segment drive.
// Latency: Load accepted at edge N gives Valid/Digits after edge N+SCORE_W+1; the scan runs continuously.
// Backpressure: Load is taken only in IDLE and is dropped, not queued, otherwise. Optional macro: SSD_LZB_EN (leading-zero blanking).
module ssd_score_scanner #(
  parameter int SCORE_W    = 8,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV_W = 18
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic [SCORE_W-1:0]      Score,
  input  logic                    Load,
  output logic                    Busy,
  output logic                    Valid,
  output logic                    Overflow,
  output logic [4*NUM_DIGITS-1:0] Digits,
  output logic [NUM_DIGITS-1:0]   An,
  output logic [6:0]              Cath,
  output logic                    Dp
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_load_acc;
  logic                    w_busy;
  logic                    w_done;
  logic [SCORE_W-1:0]      r_bin;
  logic [BCD_W-1:0]        r_bcd;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_ovf;
  logic [BCD_W-1:0]        w_bcd_adj;
  logic                    r_valid;
  logic                    r_overflow;
  logic [BCD_W-1:0]        r_digits;
  logic [SCAN_DIV_W-1:0]   r_scan;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_cath;
  logic [3:0]              w_nib;
  logic                    w_blank;
  logic [6:0]              w_cath_nxt;

  // Converter state register
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Converter next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_load_acc  = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Load) begin
          w_load_acc  = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Add-3 correction of every BCD nibble that would reach >= 10 after doubling
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Shift engine: load on accept, one double-dabble step per cycle in SHIFT
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_load_acc) begin
      r_bin <= Score;
      r_bcd <= '0;
      r_cnt <= CNT_W'(SCORE_W);
      r_ovf <= 1'b0;
    end else if (w_busy) begin
      r_bin <= r_bin << 1;
      r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[SCORE_W-1]};
      r_cnt <= r_cnt - CNT_W'(1);
      // a carry out of the top digit means the value no longer fits
      r_ovf <= r_ovf | w_bcd_adj[BCD_W-1];
    end
  end

  // Result registers, updated once per conversion and held until the next one
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_digits   <= '0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_digits   <= r_bcd;
        r_overflow <= r_ovf;
      end
    end
  end

  // Digit index advances when the free-running scan divider wraps
  always_comb begin
    w_idx_nxt = r_idx;
    if (&r_scan) w_idx_nxt = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
  end

  // Select the nibble for the upcoming digit and decide whether it is blanked
  always_comb begin
    w_nib   = 4'd0;
    w_blank = 1'b0;
`ifdef SSD_LZB_EN
    begin
      logic nz_above;
      nz_above = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
        nz_above = nz_above | (|r_digits[4*i +: 4]);
        if (IDX_W'(i) == w_idx_nxt) begin
          w_nib   = r_digits[4*i +: 4];
          w_blank = (i != 0) && !nz_above;
        end
      end
    end
`else
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == w_idx_nxt) w_nib = r_digits[4*i +: 4];
    end
`endif
  end

  // Active-low segment decode; overflow forces a dash on every digit
  always_comb begin
    case (w_nib)
      4'd0:    w_cath_nxt = 7'b0000001;
      4'd1:    w_cath_nxt = 7'b1001111;
      4'd2:    w_cath_nxt = 7'b0010010;
      4'd3:    w_cath_nxt = 7'b0000110;
      4'd4:    w_cath_nxt = 7'b1001100;
      4'd5:    w_cath_nxt = 7'b0100100;
      4'd6:    w_cath_nxt = 7'b0100000;
      4'd7:    w_cath_nxt = 7'b0001111;
      4'd8:    w_cath_nxt = 7'b0000000;
      4'd9:    w_cath_nxt = 7'b0000100;
      default: w_cath_nxt = 7'b1111111;
    endcase
    if (w_blank)    w_cath_nxt = 7'b1111111;
    if (r_overflow) w_cath_nxt = 7'b1111110;
  end

  // Scan counter, index and the anode/cathode registers switch on the same edge
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_scan <= '0;
      r_idx  <= '0;
      r_an   <= ~NUM_DIGITS'(1);
      r_cath <= 7'b0000001;
    end else begin
      r_scan <= r_scan + SCAN_DIV_W'(1);
      r_idx  <= w_idx_nxt;
      r_an   <= ~(NUM_DIGITS'(1) << w_idx_nxt);
      r_cath <= w_cath_nxt;
    end
  end

  assign Busy     = w_busy;
  assign Valid    = r_valid;
  assign Overflow = r_overflow;
  assign Digits   = r_digits;
  assign An       = r_an;
  assign Cath     = r_cath;
  assign Dp       = 1'b1;

endmodule

// File: tb/tb_ssd_score_scanner.sv
// Randomized + directed bench for ssd_score_scanner against a decimal reference model.
// Configuration: 10-bit score, 3 digits (overflow above 999), 4-cycle digit slots.
// Honors SSD_LZB_EN the same way as the design build.
module tb_ssd_score_scanner;

  localparam int SW = 10;
  localparam int ND = 3;
  localparam int DW = 2;
  localparam int SLOT = 1 << DW;

  logic          Clk = 1'b0;
  logic          reset;
  logic [SW-1:0] Score;
  logic          Load;
  logic          Busy, Valid, Overflow, Dp;
  logic [4*ND-1:0] Digits;
  logic [ND-1:0] An;
  logic [6:0]    Cath;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int disp_val = 0;
  bit disp_ovf = 1'b0;

  ssd_score_scanner #(.SCORE_W(SW), .NUM_DIGITS(ND), .SCAN_DIV_W(DW)) dut (
    .Clk(Clk), .reset(reset), .Score(Score), .Load(Load), .Busy(Busy),
    .Valid(Valid), .Overflow(Overflow), .Digits(Digits), .An(An),
    .Cath(Cath), .Dp(Dp)
  );

  always #5 Clk = ~Clk;

  // cycles since reset release drive the expected scan position
  always @(posedge Clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
  endtask

  function automatic int dec_digit(input int v, input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic logic [31:0] bcd_of(input int v);
    logic [31:0] r = '0;
    for (int i = 0; i < ND; i++) r = r | (32'(dec_digit(v, i)) << (4 * i));
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    return tbl[d];
  endfunction

  function automatic logic [6:0] exp_cath(input int pos);
    if (disp_ovf) return 7'b1111110;
`ifdef SSD_LZB_EN
    // blank when this and all higher positions are zero, except position 0
    if (pos != 0 && disp_val < 10 ** pos) return 7'b1111111;
`endif
    return seg_of(dec_digit(disp_val, pos));
  endfunction

  // one conversion; optionally fire a conflicting Load while busy
  task automatic do_conv(input int s, input bit inject, input int other);
    int vk = 0;
    int busy_cnt = 0;
    @(negedge Clk);
    Score = SW'(s);
    Load  = 1'b1;
    @(posedge Clk);
    for (int k = 1; k <= 40 && vk == 0; k++) begin
      @(negedge Clk);
      if (Busy) busy_cnt++;
      if (Valid) vk = k;
      Load = 1'b0;
      if (inject && k == 3) begin
        Score = SW'(other);
        Load  = 1'b1;
      end
    end
    Load = 1'b0;
    check("valid_latency", vk, SW + 2);
    check("busy_cycles", busy_cnt, SW);
    check("overflow", Overflow, (s > 999) ? 1 : 0);
    if (s <= 999) check("digits", Digits, bcd_of(s));
    disp_val = s;
    disp_ovf = (s > 999);
    @(negedge Clk);
    check("valid_pulse", Valid, 0);
  endtask

  // one full rotation plus a bit, checking anode and segments every cycle
  task automatic scan_check(input int n);
    for (int k = 0; k < n; k++) begin
      int pos;
      @(negedge Clk);
      pos = (cyc / SLOT) % ND;
      check("an", An, ~(32'(1) << pos) & ((1 << ND) - 1));
      check("cath", Cath, exp_cath(pos));
    end
  endtask

  initial begin
    int dir [8] = '{0, 255, 999, 1000, 1023, 42, 7, 100};
    reset = 1'b1;
    Load  = 1'b0;
    Score = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_busy", Busy, 0);
    check("rst_valid", Valid, 0);
    check("rst_ovf", Overflow, 0);
    check("rst_digits", Digits, 0);
    check("rst_an", An, 3'b110);
    check("rst_cath", Cath, 7'b0000001);
    check("rst_dp", Dp, 1);
    reset = 1'b0;
    scan_check(2 * ND * SLOT);

    foreach (dir[i]) begin
      do_conv(dir[i], 1'b0, 0);
      scan_check(ND * SLOT + 1);
    end
    for (int i = 0; i < 12; i++) begin
      int s = $urandom_range(0, 1023);
      do_conv(s, i[0], $urandom_range(0, 1023));
      scan_check(ND * SLOT + 1);
    end

    // reset mid-conversion after a nonzero result is on display
    do_conv(321, 1'b0, 0);
    @(negedge Clk);
    Score = SW'(555);
    Load  = 1'b1;
    @(posedge Clk);
    repeat (4) @(negedge Clk);
    Load  = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_digits", Digits, 0);
    check("mid_rst_valid", Valid, 0);
    check("mid_rst_an", An, 3'b110);
    check("mid_rst_cath", Cath, 7'b0000001);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    reset    = 1'b0;
    disp_val = 0;
    disp_ovf = 1'b0;
    scan_check(ND * SLOT);
    do_conv(908, 1'b0, 0);
    scan_check(ND * SLOT + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
